// File: rtl/mult_m1_pkg.sv
// mult_m1 shared types: register geometry and partial-product sign modes.
// Overflow generation is selected by the MULT_OVF_EN macro in mult_m1.
package mult_m1_pkg;

   localparam int REG_W  = 32;
   localparam int REG_AW = 5;

   // bit1: operand a is signed, bit0: operand b is signed
   typedef enum logic [1:0] {
      PP_UU = 2'b00,
      PP_US = 2'b01,
      PP_SU = 2'b10,
      PP_SS = 2'b11
   } pp_mode_e;

endpackage

// File: rtl/mult_m1_if.sv
// Issue-side request and M1/M2 boundary signals of the mult_m1 stage.
interface mult_m1_if #(
   parameter int W  = mult_m1_pkg::REG_W,
   parameter int AW = mult_m1_pkg::REG_AW
) ();
   logic          we;
   logic          flush;
   logic          valid_in;
   logic          regwrite_in;
   logic [AW-1:0] wreg_in;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          ready;
   logic          valid_out;
   logic          regwrite_out;
   logic [W-1:0]  pre_m1result;
   logic          pre_zero;
   logic          pre_overflow;
   logic [AW-1:0] dst_reg;

   modport master (
      output we, flush, valid_in, regwrite_in, wreg_in, src_a, src_b,
      input  ready, valid_out, regwrite_out, pre_m1result, pre_zero, pre_overflow, dst_reg
   );

   modport slave (
      input  we, flush, valid_in, regwrite_in, wreg_in, src_a, src_b,
      output ready, valid_out, regwrite_out, pre_m1result, pre_zero, pre_overflow, dst_reg
   );
endinterface

// File: rtl/mult_m1_pp16.sv
// Combinational (H)x(H) partial-product unit; each operand is treated as
// signed or unsigned according to mode, product is the low 2H bits.
module mult_pp16
   import mult_m1_pkg::*;
#(
   parameter int H = 16
) (
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   input  pp_mode_e       mode,
   output logic [2*H-1:0] p
);
   logic              a_sgn, b_sgn;
   logic signed [H:0]     ax, bx;
   logic signed [2*H+1:0] full;
   logic              unused_top;

   assign a_sgn = (mode == PP_SU) || (mode == PP_SS);
   assign b_sgn = (mode == PP_US) || (mode == PP_SS);

   // one extra bit lets a single signed multiplier cover all four modes
   assign ax   = {a_sgn & a[H-1], a};
   assign bx   = {b_sgn & b[H-1], b};
   assign full = ax * bx;

   assign p          = full[2*H-1:0];
   assign unused_top = ^full[2*H+1:2*H];
endmodule

// File: rtl/mult_m1.sv
// M1 multiply stage: signed WxW product from four half-width partial products,
// zero/overflow flags, and the M1/M2 stage register. MULT_OVF_EN enables overflow.
module mult_m1
   import mult_m1_pkg::*;
#(
   parameter int W  = REG_W,
   parameter int AW = REG_AW
) (
   input  logic      clk,
   input  logic      reset,
   mult_m1_if.slave  bus
);
   localparam int H = W / 2;
`ifdef MULT_OVF_EN
   localparam int NPP = 4;
`else
   localparam int NPP = 3;
`endif

   if ((W % 2) != 0) begin : g_bad_w
      $error("mult_m1: W must be even");
   end

   logic [H-1:0]            a_lo, a_hi, b_lo, b_hi;
   logic [NPP-1:0][W-1:0]   pp;
   logic [W-1:0]            res_c;
   logic                    ovf_c;

   assign a_lo = bus.src_a[H-1:0];
   assign a_hi = bus.src_a[W-1:H];
   assign b_lo = bus.src_b[H-1:0];
   assign b_hi = bus.src_b[W-1:H];

   // index bit1 selects the high half of a, bit0 the high half of b;
   // the high halves carry the sign, so the index doubles as the sign mode
   for (genvar i = 0; i < NPP; i++) begin : g_pp
      localparam logic [1:0] MI = 2'(i);
      mult_pp16 #(.H(H)) u_pp (
         .a    (MI[1] ? a_hi : a_lo),
         .b    (MI[0] ? b_hi : b_lo),
         .mode (pp_mode_e'(MI)),
         .p    (pp[i])
      );
   end

`ifdef MULT_OVF_EN
   logic [2*W-1:0] prod;

   assign prod = {{W{1'b0}}, pp[0]}
               + {{H{pp[1][W-1]}}, pp[1], {H{1'b0}}}
               + {{H{pp[2][W-1]}}, pp[2], {H{1'b0}}}
               + {pp[3], {W{1'b0}}};
   assign res_c = prod[W-1:0];
   assign ovf_c = prod[2*W-1:W] != {W{prod[W-1]}};
`else
   // only the low word is needed: cross terms contribute just their low halves
   logic unused_hi;

   assign res_c     = pp[0] + {pp[1][H-1:0], {H{1'b0}}} + {pp[2][H-1:0], {H{1'b0}}};
   assign ovf_c     = 1'b0;
   assign unused_hi = ^{pp[1][W-1:H], pp[2][W-1:H], ovf_c};
`endif

   assign bus.ready = bus.we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.valid_out    <= 1'b0;
         bus.regwrite_out <= 1'b0;
         bus.pre_m1result <= '0;
         bus.pre_zero     <= 1'b0;
         bus.dst_reg      <= '0;
      end else if (bus.flush) begin
         bus.valid_out    <= 1'b0;
         bus.regwrite_out <= 1'b0;
         bus.pre_m1result <= '0;
         bus.pre_zero     <= 1'b0;
         bus.dst_reg      <= '0;
      end else if (bus.we) begin
         bus.valid_out    <= bus.valid_in;
         bus.regwrite_out <= bus.valid_in & bus.regwrite_in;
         bus.pre_m1result <= res_c;
         bus.pre_zero     <= (res_c == '0);
         bus.dst_reg      <= bus.wreg_in;
      end
   end

`ifdef MULT_OVF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         bus.pre_overflow <= 1'b0;
      else if (bus.flush) bus.pre_overflow <= 1'b0;
      else if (bus.we)    bus.pre_overflow <= ovf_c;
   end
`else
   assign bus.pre_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_mult_m1.sv
// Directed + random bench for mult_m1 with a queue scoreboard and 64-bit model.
module tb_mult_m1;
   typedef struct packed {
      logic        v;
      logic        rw;
      logic [31:0] r;
      logic        z;
      logic        o;
      logic [4:0]  d;
   } out_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   out_t exp_q[$];
   out_t last;

   mult_m1_if #(.W(32), .AW(5)) bus ();

   mult_m1 #(.W(32), .AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t model(input logic v, rw, input logic [4:0] d,
                                  input logic [31:0] a, b);
      out_t   e;
      longint p;
      p    = longint'($signed(a)) * longint'($signed(b));
      e.v  = v;
      e.rw = v & rw;
      e.r  = p[31:0];
      e.z  = (p[31:0] == 32'd0);
`ifdef MULT_OVF_EN
      e.o  = (p[63:32] != {32{p[31]}});
`else
      e.o  = 1'b0;
`endif
      e.d  = d;
      return e;
   endfunction

   function automatic out_t observed();
      out_t o;
      o.v  = bus.valid_out;
      o.rw = bus.regwrite_out;
      o.r  = bus.pre_m1result;
      o.z  = bus.pre_zero;
      o.o  = bus.pre_overflow;
      o.d  = bus.dst_reg;
      return o;
   endfunction

   task automatic check(input string tag, input out_t e);
      out_t o;
      o = observed();
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // drive one cycle of stimulus, push the model result, pop and compare after the edge
   task automatic step(input string tag, input logic we_i, fl_i, v_i, rw_i,
                       input logic [4:0] wr_i, input logic [31:0] a_i, b_i);
      out_t e;
      bus.we          = we_i;
      bus.flush       = fl_i;
      bus.valid_in    = v_i;
      bus.regwrite_in = rw_i;
      bus.wreg_in     = wr_i;
      bus.src_a       = a_i;
      bus.src_b       = b_i;
      #1;
      vectors++;
      assert (bus.ready === we_i) else begin
         miscompares++;
         $error("FAIL %s_ready: observed %b expected %b", tag, bus.ready, we_i);
      end
      if (fl_i)      e = '0;
      else if (we_i) e = model(v_i, rw_i, wr_i, a_i, b_i);
      else           e = last;
      exp_q.push_back(e);
      last = e;
      @(posedge clk);
      #1;
      check(tag, exp_q.pop_front());
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      last        = '0;
      reset       = 1'b0;
      bus.we = 1'b0; bus.flush = 1'b0; bus.valid_in = 1'b0; bus.regwrite_in = 1'b0;
      bus.wreg_in = '0; bus.src_a = '0; bus.src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", '0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      step("basic_7x6",   1, 0, 1, 1, 5'd3,  32'd7,        32'd6);
      step("neg5_x0",     1, 0, 1, 1, 5'd4,  32'hFFFFFFFB, 32'd0);
      step("neg5_x3",     1, 0, 1, 1, 5'd5,  32'hFFFFFFFB, 32'd3);
      step("ovf_2p16sq",  1, 0, 1, 1, 5'd6,  32'h00010000, 32'h00010000);
      step("cap_2x3",     1, 0, 1, 1, 5'd7,  32'd2,        32'd3);
      step("stall_1",     0, 0, 1, 1, 5'd9,  32'd100,      32'd100);
      step("stall_2",     0, 0, 0, 0, 5'd10, 32'hDEADBEEF, 32'd5);
      step("stall_3",     0, 0, 1, 1, 5'd11, 32'h12345678, 32'h9);
      step("max_x2",      1, 0, 1, 1, 5'd12, 32'h7FFFFFFF, 32'd2);
      step("flush_nowe",  0, 1, 1, 1, 5'd13, 32'd9,        32'd9);
      step("bubble_rw",   1, 0, 0, 1, 5'd14, 32'd11,       32'd13);
      step("valid_norw",  1, 0, 1, 0, 5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);
      step("min_sq",      1, 0, 1, 1, 5'd16, 32'h80000000, 32'h80000000);
      step("flush_we",    1, 1, 1, 1, 5'd17, 32'd3,        32'd4);
      step("mixed_sign",  1, 0, 1, 1, 5'd18, 32'hFFFF8000, 32'h00017FFF);

      for (int i = 0; i < 12; i++) begin
         step("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
              1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
      end

      // reset in the middle of a stall clears immediately, then capture resumes
      step("pre_rst",     1, 0, 1, 1, 5'd21, 32'd5,        32'd5);
      step("rst_stall",   0, 0, 1, 1, 5'd22, 32'd8,        32'd8);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset", '0);
      @(negedge clk);
      reset = 1'b1;
      last  = '0;
      @(posedge clk);
      #1;
      step("post_rst",    1, 0, 1, 1, 5'd23, 32'hFFFFFFFE, 32'd21);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
